// File: rtl/mul_share_arbiter.sv
// Two-requester front end for one shared shift-add multiplier.
// Round-robin grant, zero-operand bypass and hung-run timeout.
module mul_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  output logic               rsp0_valid,
  output logic [2*WIDTH-1:0] rsp0_prod,
  output logic               rsp0_err,
  input  logic               rsp0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp1_valid,
  output logic [2*WIDTH-1:0] rsp1_prod,
  output logic               rsp1_err,
  input  logic               rsp1_ready,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_prod
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t               state;
  logic                 ptr;
  logic                 owner;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 err_q;
  logic [7:0]           cnt;
  logic                 rsp0_v;
  logic                 rsp1_v;

  logic                 grant;
  logic                 idle;
  logic                 acc0;
  logic                 acc1;
  logic                 accept;
  logic [WIDTH-1:0]     acc_a;
  logic [WIDTH-1:0]     acc_b;
  logic                 hs;
  logic                 run;
  logic                 expire;

  assign idle = (state == IDLE);

  always_comb begin
    grant = ptr;
    unique case (1'b1)
      (req0_valid && !req1_valid): grant = 1'b0;
      (!req0_valid && req1_valid): grant = 1'b1;
      default:                     grant = ptr;
    endcase
  end

  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;

  assign acc0   = req0_valid && req0_ready;
  assign acc1   = req1_valid && req1_ready;
  assign accept = acc0 || acc1;
  assign acc_a  = acc1 ? req1_a : req0_a;
  assign acc_b  = acc1 ? req1_b : req0_b;

  assign hs = (rsp0_v && rsp0_ready) || (rsp1_v && rsp1_ready);

  // Operands are only exposed while a run is in flight.
  assign run   = (state == ISSUE) || (state == WAIT);
  assign mul_a = run ? a_q : '0;
  assign mul_b = run ? b_q : '0;

  assign expire = (cnt + 8'd1) == 8'(TIMEOUT);

  assign rsp0_valid = rsp0_v;
  assign rsp1_valid = rsp1_v;
  assign rsp0_prod  = rsp0_v ? prod_q : '0;
  assign rsp1_prod  = rsp1_v ? prod_q : '0;
  assign rsp0_err   = rsp0_v && err_q;
  assign rsp1_err   = rsp1_v && err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      rsp0_v    <= 1'b0;
      rsp1_v    <= 1'b0;
      mul_start <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= acc_a;
            b_q   <= acc_b;
            owner <= acc1;
            if (acc_a == '0 || acc_b == '0) begin
              prod_q <= '0;
              err_q  <= 1'b0;
              rsp0_v <= acc0;
              rsp1_v <= acc1;
              state  <= RESP;
            end else begin
              mul_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // A finishing run wins over an expiring counter.
          if (mul_done) begin
            prod_q <= mul_prod;
            err_q  <= 1'b0;
            rsp0_v <= !owner;
            rsp1_v <= owner;
            state  <= RESP;
          end else if (expire) begin
            prod_q <= '0;
            err_q  <= 1'b1;
            rsp0_v <= !owner;
            rsp1_v <= owner;
            state  <= RESP;
          end
        end
        RESP: begin
          if (hs) begin
            rsp0_v <= 1'b0;
            rsp1_v <= 1'b0;
            ptr    <= ~owner;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
